// File: rtl/snitch_tcdm_bank_adapter.sv
// rtl/snitch_tcdm_bank_adapter.sv - single-bank request/response front end for one TCDM SRAM bank
module snitch_tcdm_bank_adapter #(
    parameter int unsigned TCDMDepth = 512,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = $clog2(TCDMDepth),
    parameter int unsigned RspDepth  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    input  logic [DataWidth-1:0]   req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_data_o,
    output logic                   mem_cs_o,
    output logic                   mem_wen_o,
    output logic [AddrWidth-1:0]   mem_add_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);

    logic                 rd_pend_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [DataWidth-1:0] fifo_q [RspDepth];

    logic                 push;
    logic                 pop;
    logic                 rd_accept;
    logic [CntWidth:0]    credits_used;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (32'(p) == RspDepth - 1) begin
            return '0;
        end
        return p + PtrWidth'(1);
    endfunction

    assign rsp_valid_o = (cnt_q != '0);
    assign rsp_data_o  = fifo_q[rd_ptr_q];
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign push        = rd_pend_q;

    // Every accepted read owns a FIFO slot from acceptance until it is popped,
    // so the in-flight read counts against the credit just like a stored entry.
    assign credits_used = {1'b0, cnt_q}
                        + {{CntWidth{1'b0}}, rd_pend_q}
                        - {{CntWidth{1'b0}}, pop};
    assign req_ready_o  = !rst_i && (credits_used < (CntWidth + 1)'(RspDepth));

    assign mem_cs_o    = req_valid_i & req_ready_o;
    assign mem_wen_o   = req_write_i;
    assign mem_add_o   = req_addr_i;
    assign mem_be_o    = req_strb_i;
    assign mem_wdata_o = req_data_i;

    assign rd_accept = mem_cs_o & ~req_write_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_q <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            rd_pend_q <= rd_accept;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

    // Payload storage needs no reset: entries are only visible through cnt_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && (32'(cnt_q) == RspDepth)));
        end
        assert (!(rst_i && req_ready_o));
        assert (!mem_cs_o || req_valid_i);
    end

endmodule

// File: tb/tb_snitch_tcdm_bank_adapter.sv
// tb/tb_snitch_tcdm_bank_adapter.sv - self-checking bench for snitch_tcdm_bank_adapter
module tb_snitch_tcdm_bank_adapter;

    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam int DEPTH = 512;
    localparam int RSP   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [SW-1:0] req_strb = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          mem_cs;
    logic          mem_wen;
    logic [AW-1:0] mem_add;
    logic [SW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    snitch_tcdm_bank_adapter #(
        .TCDMDepth(DEPTH),
        .DataWidth(DW),
        .RspDepth (RSP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_write_i(req_write),
        .req_addr_i (req_addr),
        .req_strb_i (req_strb),
        .req_data_i (req_data),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .mem_cs_o   (mem_cs),
        .mem_wen_o  (mem_wen),
        .mem_add_o  (mem_add),
        .mem_be_o   (mem_be),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural latency-1 SRAM with byte enables
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wen) begin
                for (int b = 0; b < SW; b++) begin
                    if (mem_be[b]) ram[mem_add][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_add];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic          valid;
        logic          write;
        logic [AW-1:0] addr;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
        logic          rrdy;
        logic          e_ready;
        logic          e_cs;
        logic          e_rv;
        logic [DW-1:0] e_data;
    } vec_t;

    function automatic vec_t v(input logic vl, input logic wr, input logic [AW-1:0] a,
                               input logic [SW-1:0] s, input logic [DW-1:0] d, input logic rr,
                               input logic er, input logic ec, input logic ev,
                               input logic [DW-1:0] ed);
        vec_t r;
        r.valid = vl; r.write = wr; r.addr = a; r.strb = s; r.data = d; r.rrdy = rr;
        r.e_ready = er; r.e_cs = ec; r.e_rv = ev; r.e_data = ed;
        return r;
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(i) * 32'h0101_0101, 32'hC0DE_0000 + 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic vl, input logic wr, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input logic [DW-1:0] d, input logic rr);
        @(posedge clk);
        #1;
        rst = r; req_valid = vl; req_write = wr; req_addr = a;
        req_strb = s; req_data = d; rsp_ready = rr;
        @(negedge clk);
    endtask

    localparam logic [DW-1:0] D0   = 64'hDEADBEEF_CAFEF00D;
    localparam logic [DW-1:0] ONES = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [DW-1:0] HALF = 64'hFFFFFFFF_00000000;
    localparam logic [DW-1:0] Z0   = 64'h01234567_89ABCDEF;
    localparam logic [DW-1:0] ZL   = 64'hA5A55A5A_0F0FF0F0;
    localparam logic [DW-1:0] F2   = 64'h13579BDF_2468ACE0;

    vec_t vt[$];
    logic [DW-1:0] q[$];

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        // single write then read
        vt.push_back(v(1, 1, 5, 8'hFF, D0, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 0, 5, 0, 0, 1, 1, 1, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, D0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // byte strobes, boundary addresses, strb=0 no-op
        vt.push_back(v(1, 1, 7, 8'hFF, ONES, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 1, 7, 8'h0F, 0, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 1, 0, 8'hFF, Z0, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 1, 0, 8'h00, ONES, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 1, 511, 8'hFF, ZL, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 0, 7, 0, 0, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 0, 511, 0, 0, 1, 1, 1, 1, HALF));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, Z0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, ZL));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // backpressure: two credits, then stall, then drain
        vt.push_back(v(1, 0, 5, 0, 0, 0, 1, 1, 0, 0));
        vt.push_back(v(1, 0, 7, 0, 0, 0, 1, 1, 0, 0));
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, D0));
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, D0));
        vt.push_back(v(1, 0, 0, 0, 0, 1, 1, 1, 1, D0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, HALF));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, Z0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        // reset state
        drive(1, 1, 0, 3, 0, 0, 1);
        drive(1, 1, 0, 3, 0, 0, 1);
        chk("rst.ready", req_ready, 0);
        chk("rst.cs", mem_cs, 0);
        chk("rst.rv", rsp_valid, 0);
        chk("rst.cnt", dut.cnt_q, 0);

        foreach (vt[i]) begin
            drive(0, vt[i].valid, vt[i].write, vt[i].addr, vt[i].strb, vt[i].data, vt[i].rrdy);
            chk($sformatf("vec%0d.ready", i), req_ready, vt[i].e_ready);
            chk($sformatf("vec%0d.cs", i), mem_cs, vt[i].e_cs);
            chk($sformatf("vec%0d.rv", i), rsp_valid, vt[i].e_rv);
            if (vt[i].e_rv) chk($sformatf("vec%0d.data", i), rsp_data, vt[i].e_data);
        end

        // streaming: 16 back-to-back reads at full throughput
        for (int i = 0; i < 16; i++) drive(0, 1, 1, AW'(16 + i), 8'hFF, pat(i), 1);
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drive(0, 1, 0, AW'(16 + c), 0, 0, 1);
            else        drive(0, 0, 0, 0, 0, 0, 1);
            if (c < 16) chk($sformatf("stream%0d.ready", c), req_ready, 1);
            if (c >= 2) begin
                chk($sformatf("stream%0d.rv", c), rsp_valid, 1);
                chk($sformatf("stream%0d.data", c), rsp_data, pat(c - 2));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("stream.end.rv", rsp_valid, 0);

        // reset with one entry queued and one read in flight
        drive(0, 1, 0, 5, 0, 0, 0);
        drive(0, 1, 0, 7, 0, 0, 0);
        drive(1, 1, 0, 5, 0, 0, 0);
        chk("midrst.ready", req_ready, 0);
        chk("midrst.cs", mem_cs, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("midrst.rv", rsp_valid, 0);
        chk("midrst.cnt", dut.cnt_q, 0);
        chk("midrst.pend", dut.rd_pend_q, 0);
        drive(0, 1, 1, 5, 8'hFF, F2, 1);
        chk("midrst.rv2", rsp_valid, 0);
        drive(0, 1, 0, 5, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("midrst.rv3", rsp_valid, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("midrst.fresh.rv", rsp_valid, 1);
        chk("midrst.fresh.data", rsp_data, F2);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("midrst.after.rv", rsp_valid, 0);

        // random mixed traffic against a scoreboard
        for (int i = 0; i < DEPTH; i++) shadow[i] = ram[i];
        begin
            int accepted = 0;
            int cyc = 0;
            while (accepted < 10000 && cyc < 40000) begin
                logic vl, wr, rr, pop, exp_rdy;
                logic [AW-1:0] a;
                logic [SW-1:0] s;
                logic [DW-1:0] d;
                int sel;
                vl  = ($urandom_range(0, 3) != 0);
                wr  = $urandom_range(0, 1) == 1;
                sel = $urandom_range(0, 9);
                a   = (sel == 0) ? AW'(0) : (sel == 1) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 31));
                s   = SW'($urandom_range(0, 255));
                d   = {$urandom, $urandom};
                rr  = ($urandom_range(0, 3) != 0);
                drive(0, vl, wr, a, s, d, rr);
                pop     = rsp_valid & rr;
                exp_rdy = (q.size() - (pop ? 1 : 0)) < RSP;
                chk($sformatf("rnd%0d.ready", cyc), req_ready, exp_rdy);
                chk($sformatf("rnd%0d.cs", cyc), mem_cs, vl & exp_rdy);
                if (pop) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rnd%0d.spurious", cyc), 1, 0);
                    end else begin
                        chk($sformatf("rnd%0d.data", cyc), rsp_data, q.pop_front());
                    end
                end
                if (vl && req_ready) begin
                    accepted++;
                    if (wr) begin
                        for (int b = 0; b < SW; b++) if (s[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
                    end else begin
                        q.push_back(shadow[a]);
                    end
                end
                cyc++;
            end
            chk("rnd.accepted", 32'(accepted), 32'd10000);
            for (int c = 0; c < 4; c++) begin
                drive(0, 0, 0, 0, 0, 0, 1);
                if (rsp_valid) begin
                    if (q.size() == 0) chk("drain.spurious", 1, 0);
                    else chk($sformatf("drain%0d.data", c), rsp_data, q.pop_front());
                end
            end
            chk("drain.left", 32'(q.size()), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
